bullet_slot_arbiter: RTL

BULLET_SLOT_ARBITER -- requirements
Module: bullet_slot_arbiter

---
 rtl/bullet_slot_arbiter.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/bullet_slot_arbiter.sv
// bullet_slot_arbiter
//   Hands out bullet slots to fire-button requests, at most one grant per
//   game tick, with a post-launch cooldown measured in ticks.
//
// Ports
//   iCLK, iRST_N          clock, async active-low reset
//   iTICK                 one-cycle 60 Hz game strobe
//   iFIRE_UP/iFIRE_DN     raw button levels (asynchronous)
//   iSLOT_DONE[N]         per-slot pulse: bullet left the screen
//   oLAUNCH[N]            one-cycle load pulse for the granted slot
//   oDIR[N]               per-slot direction (1 = up), valid while busy
//   oBUSY[N]              per-slot occupancy
//   oFULL                 all slots busy
//   oSHOT_CNT[8]          grants issued, modulo 256

// Button synchronizer plus rising-edge detector.
module bsa_fire_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic fire,
    output logic rise
);
    logic s1, s2, prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            prev <= 1'b0;
        end else begin
            s1   <= fire;
            s2   <= s1;
            prev <= s2;
        end
    end

    // Flops clear in reset, so a button held through release yields one edge.
    assign rise = s2 & ~prev;
endmodule

// Per-slot occupancy, direction and launch pulse.
module bsa_slot (
    input  logic clk,
    input  logic rst_n,
    input  logic grant,
    input  logic grant_dir,
    input  logic done,
    output logic launch,
    output logic busy,
    output logic dir
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            launch <= 1'b0;
            busy   <= 1'b0;
            dir    <= 1'b0;
        end else begin
            launch <= grant;
            // A grant only ever targets a free slot, so it cannot collide
            // with a done pulse; done on a free slot is a no-op.
            if (grant) begin
                busy <= 1'b1;
                dir  <= grant_dir;
            end else if (done) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

module bullet_slot_arbiter #(
    parameter int N_SLOTS  = 4,
    parameter int COOLDOWN = 8
) (
    input  logic               iCLK,
    input  logic               iRST_N,
    input  logic               iTICK,
    input  logic               iFIRE_UP,
    input  logic               iFIRE_DN,
    input  logic [N_SLOTS-1:0] iSLOT_DONE,
    output logic [N_SLOTS-1:0] oLAUNCH,
    output logic [N_SLOTS-1:0] oDIR,
    output logic [N_SLOTS-1:0] oBUSY,
    output logic               oFULL,
    output logic [7:0]         oSHOT_CNT
);
    localparam int CW = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

    typedef enum logic [1:0] {IDLE, LAUNCH, COOL} state_t;

    state_t             state;
    logic [CW-1:0]      cool_cnt;
    logic               pend_up, pend_dn;
    logic               rr_up;
    logic               rise_up, rise_dn;
    logic               can_grant, grant_up;
    logic [N_SLOTS-1:0] lowest_free, grant_vec, busy_nxt;

    bsa_fire_sync u_sync_up (.clk(iCLK), .rst_n(iRST_N), .fire(iFIRE_UP), .rise(rise_up));
    bsa_fire_sync u_sync_dn (.clk(iCLK), .rst_n(iRST_N), .fire(iFIRE_DN), .rise(rise_dn));

    // Grant decision uses the registered busy vector, so a slot freed this
    // cycle is not a candidate until the next tick.
    assign can_grant   = (state == IDLE) && iTICK && (pend_up || pend_dn) && !(&oBUSY);
    assign grant_up    = pend_up && (!pend_dn || rr_up);
    // Lowest clear bit of busy: adding one ripples through the low ones.
    assign lowest_free = ~oBUSY & (oBUSY + N_SLOTS'(1));
    assign grant_vec   = can_grant ? lowest_free : '0;
    assign busy_nxt    = (oBUSY & ~iSLOT_DONE) | grant_vec;

    for (genvar g = 0; g < N_SLOTS; g++) begin : g_slot
        bsa_slot u_slot (
            .clk      (iCLK),
            .rst_n    (iRST_N),
            .grant    (grant_vec[g]),
            .grant_dir(grant_up),
            .done     (iSLOT_DONE[g]),
            .launch   (oLAUNCH[g]),
            .busy     (oBUSY[g]),
            .dir      (oDIR[g])
        );
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            state     <= IDLE;
            cool_cnt  <= '0;
            pend_up   <= 1'b0;
            pend_dn   <= 1'b0;
            rr_up     <= 1'b1;
            oSHOT_CNT <= 8'd0;
            oFULL     <= 1'b0;
        end else begin
            // Pending flags keep collecting in every state; a clear for the
            // granted direction wins over a coincident new edge.
            pend_up <= (pend_up | rise_up) & ~(can_grant &  grant_up);
            pend_dn <= (pend_dn | rise_dn) & ~(can_grant & ~grant_up);
            oFULL   <= &busy_nxt;
            case (state)
                IDLE: begin
                    if (can_grant) begin
                        state     <= LAUNCH;
                        cool_cnt  <= CW'(COOLDOWN);
                        oSHOT_CNT <= oSHOT_CNT + 8'd1;
                        if (pend_up && pend_dn)
                            rr_up <= ~rr_up;
                    end
                end
                LAUNCH: begin
                    state <= (COOLDOWN > 0) ? COOL : IDLE;
                end
                COOL: begin
                    if (iTICK) begin
                        cool_cnt <= cool_cnt - CW'(1);
                        if (cool_cnt == CW'(1))
                            state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
